// File: rtl/spio_aer_packet_builder.sv
// AER event to SpiNNaker multicast packet builder: event FIFO with optional
// timestamp capture, single valid/ready output register, parity generation.
module spio_aer_packet_builder #(
    parameter int          ADDR_BITS    = 16,
    parameter int          FIFO_LOG2    = 4,
    parameter logic [31:0] KEY_BASE     = 32'h0000_0000,
    parameter bit          TS_EN        = 1'b0,
    parameter bit          DROP_ON_FULL = 1'b1
) (
    input  logic                 CLK_IN,
    input  logic                 RESET_IN,
    input  logic [ADDR_BITS-1:0] AER_ADDR_IN,
    input  logic                 AER_VLD_IN,
    output logic                 AER_RDY_OUT,
    output logic [71:0]          PKT_DATA_OUT,
    output logic                 PKT_VLD_OUT,
    input  logic                 PKT_RDY_IN,
    output logic [15:0]          DROP_CNT_OUT,
    output logic [FIFO_LOG2:0]   FIFO_LVL_OUT
);

    localparam int                 DEPTH    = 2 ** FIFO_LOG2;
    localparam int                 ENTRY_W  = ADDR_BITS + 32;
    localparam logic [FIFO_LOG2:0] FULL_LVL = {1'b1, {FIFO_LOG2{1'b0}}};

    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   lvl_q, lvl_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic [31:0]          ts_q, ts_d;
    logic                 rdy_q, rdy_d;
    logic                 vld_q, vld_d;
    logic [71:0]          data_q, data_d;

    logic                 full, empty, push, drop, pop;
    logic [ADDR_BITS-1:0] head_addr;
    logic [31:0]          head_ts;
    logic [71:0]          pkt;

    function automatic logic odd_parity(input logic [71:0] body);
        return ~^body;
    endfunction

    always_comb begin
        full  = (lvl_q == FULL_LVL);
        empty = (lvl_q == '0);
        // rdy_q already tracks !full when back-pressuring, so drop can only fire in drop mode
        push  = AER_VLD_IN && rdy_q && !full;
        drop  = AER_VLD_IN && rdy_q && full;
        pop   = !empty && (!vld_q || PKT_RDY_IN);

        {head_ts, head_addr} = mem_q[rd_ptr_q];

        pkt        = '0;
        pkt[1]     = TS_EN;
        pkt[39:8]  = KEY_BASE | 32'(head_addr);
        if (TS_EN) begin
            pkt[71:40] = head_ts;
        end
        pkt[0]     = odd_parity(pkt);

        wr_ptr_d = push ? wr_ptr_q + FIFO_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_LOG2'(1) : rd_ptr_q;

        lvl_d = lvl_q;
        if (push && !pop) begin
            lvl_d = lvl_q + (FIFO_LOG2 + 1)'(1);
        end else if (!push && pop) begin
            lvl_d = lvl_q - (FIFO_LOG2 + 1)'(1);
        end

        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'(1) : drop_cnt_q;
        ts_d       = ts_q + 32'(1);
        rdy_d      = DROP_ON_FULL ? 1'b1 : (lvl_d != FULL_LVL);

        vld_d  = vld_q;
        data_d = data_q;
        if (pop) begin
            vld_d  = 1'b1;
            data_d = pkt;
        end else if (PKT_RDY_IN) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ts_q, AER_ADDR_IN};
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lvl_q      <= '0;
            drop_cnt_q <= '0;
            ts_q       <= '0;
            rdy_q      <= 1'b0;
            vld_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lvl_q      <= lvl_d;
            drop_cnt_q <= drop_cnt_d;
            ts_q       <= ts_d;
            rdy_q      <= rdy_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
        end
    end

    assign AER_RDY_OUT  = rdy_q;
    assign PKT_VLD_OUT  = vld_q;
    assign PKT_DATA_OUT = data_q;
    assign DROP_CNT_OUT = drop_cnt_q;
    assign FIFO_LVL_OUT = lvl_q;

endmodule
